// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared FSM state type and default operand width
package serial_add_ctrl_pkg;
  localparam int WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// serial_add_ctrl_fa: 1-bit full-adder cell
module serial_add_ctrl_fa (
  input  logic x,
  input  logic y,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S = x ^ y ^ Cin;
  assign Cout = (x & y) | (Cin & (x ^ y));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial LSB-first add/subtract sequencer around one full-adder cell
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] ra, rb, nxt;
  logic [WIDTH-2:0] rs;
  logic [CW-1:0] cnt;
  logic c, s, co, last;
  assign last = cnt == CW'(WIDTH - 1);
  assign nxt = {s, rs};
  serial_add_ctrl_fa u_fa (.x(ra[0]), .y(rb[0]), .Cin(c), .S(s), .Cout(co));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      c <= 1'b0;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= op_sub ? ~b : b;
          c <= op_sub | cin;
          cnt <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          rs <= nxt[WIDTH-1:1];
          c <= co;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            sum <= nxt;
            cout <= co;
            ovf <= c ^ co;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vector and corner-sequence bench for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, start, op_sub, cin, busy, done, cout, ovf;
  logic [W-1:0] a, b, sum;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic cin;
    logic [W-1:0] s;
    logic co;
    logic ov;
  } vec_t;
  vec_t v[10];
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input vec_t t);
    int n;
    n = 0;
    op_sub = t.sub; a = t.a; b = t.b; cin = t.cin; start = 1'b1;
    tick;
    start = 1'b0; a = ~t.a; b = ~t.b; cin = ~t.cin; op_sub = ~t.sub;
    do begin
      tick;
      n++;
    end while (!done && n < 20);
    chk("latency", n, W);
    chk("sum", sum, t.s);
    chk("cout", cout, t.co);
    chk("ovf", ovf, t.ov);
    chk("busy_at_done", busy, 1);
    tick;
    chk("done_width", done, 0);
    chk("busy_after", busy, 0);
  endtask
  initial begin
    int nd, last_i;
    logic pd;
    logic [W-1:0] cap;
    v[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    v[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    v[2] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    v[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    v[5] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    v[6] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    v[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    v[8] = '{1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0};
    v[9] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 10; i++) run_op(v[i]);
    op_sub = 1'b0; a = 8'h10; b = 8'h20; cin = 1'b1; start = 1'b1;
    tick;
    nd = 0;
    cap = '0;
    for (int i = 1; i <= 20; i++) begin
      start = (i == 3 || i == 5);
      op_sub = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
      tick;
      if (done) begin
        nd++;
        cap = sum;
      end
    end
    chk("ignore_done_count", nd, 1);
    chk("ignore_sum", cap, 8'h31);
    chk("ignore_idle", busy, 0);
    op_sub = 1'b0; a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(v[2]);
    op_sub = 1'b0; a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    nd = 0;
    last_i = -1;
    pd = 1'b0;
    for (int i = 0; i < 46; i++) begin
      tick;
      if (pd) chk("b2b_width", done, 0);
      if (done) begin
        if (last_i >= 0) chk("b2b_period", i - last_i, W + 2);
        chk("b2b_sum", sum, 8'h07);
        nd++;
        last_i = i;
      end
      pd = done;
    end
    start = 1'b0;
    chk("b2b_count", nd, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
